// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU / load-store producers and the
// register-file write arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 3
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic              reg_write_enable;
    logic [ADDR_W-1:0] reg_write_address;
    logic [DATA_W-1:0] write_data;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output alu_stall, lsu_ready,
        output reg_write_enable, reg_write_address,
        output write_data, fifo_count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  alu_stall, lsu_ready,
        input  reg_write_enable, reg_write_address,
        input  write_data, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges the ALU path and the buffered load/multiply path onto the
// single register-file write port, with r0 suppression and anti-starvation.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STARVE = 3
) (
    input logic clock,
    input logic Reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SC_W  = $clog2(MAX_STARVE + 1);

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [SC_W-1:0]   starve;

    logic fifo_empty;
    logic fifo_full;
    logic starved;
    logic ready;
    logic stall;
    logic alu_req;
    logic push;
    logic pop;
    logic take_alu;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign starved    = (starve == SC_W'(MAX_STARVE));

    // Both handshake outputs come from registered state only.
    assign ready    = !Reset && !fifo_full;
    assign stall    = !Reset && starved && !fifo_empty;
    assign alu_req  = bus.alu_valid && (bus.alu_addr != '0);
    assign push     = bus.lsu_valid && ready && (bus.lsu_addr != '0);
    assign pop      = stall || (!alu_req && !fifo_empty);
    assign take_alu = alu_req && !stall;

    assign bus.lsu_ready  = ready;
    assign bus.alu_stall  = stall;
    assign bus.fifo_count = count;

    // FIFO storage is data-only, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_addr[wr_ptr] <= bus.lsu_addr;
            mem_data[wr_ptr] <= bus.lsu_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Count consecutive ALU wins that left a FIFO entry waiting.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset)
            starve <= '0;
        else if (pop || fifo_empty)
            starve <= '0;
        else if (take_alu && !starved)
            starve <= starve + SC_W'(1);
    end

    // Registered register-file write port.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            bus.reg_write_enable  <= 1'b0;
            bus.reg_write_address <= '0;
            bus.write_data        <= '0;
        end else if (pop) begin
            bus.reg_write_enable  <= 1'b1;
            bus.reg_write_address <= mem_addr[rd_ptr];
            bus.write_data        <= mem_data[rd_ptr];
        end else if (take_alu) begin
            bus.reg_write_enable  <= 1'b1;
            bus.reg_write_address <= bus.alu_addr;
            bus.write_data        <= bus.alu_data;
        end else begin
            bus.reg_write_enable  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// queue-based reference model of the writeback rules.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 4;
    localparam int MS = 3;
    localparam int CW = 3;

    logic clock;
    logic Reset;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus2 ();

    regfile_wb_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D), .MAX_STARVE(MS)
    ) dut (
        .clock(clock), .Reset(Reset), .bus(bus.slave)
    );

    regfile_wb_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D), .MAX_STARVE(15)
    ) dut_fill (
        .clock(clock), .Reset(Reset), .bus(bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    int            starve;
    int            m_cnt;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_stall;
    logic          m_ready;

    logic          s_stall;
    logic          s_ready;
    logic [CW-1:0] s_cnt;

    task automatic model_reset();
        q.delete();
        starve = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic step(input logic av, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic lv,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld);
        int   n0;
        bit   popped;
        ent_t e;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_addr  = la;
        bus.lsu_data  = ld;
        #1;
        s_stall = bus.alu_stall;
        s_ready = bus.lsu_ready;
        s_cnt   = bus.fifo_count;
        n0      = q.size();
        m_cnt   = n0;
        m_ready = (n0 != D);
        m_stall = (starve == MS) && (n0 != 0);
        @(posedge clock);
        popped = 0;
        m_we   = 1'b0;
        if (m_stall || (!(av && aa != 0) && n0 != 0)) begin
            e      = q.pop_front();
            popped = 1;
            m_we   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
        end else if (av && aa != 0) begin
            m_we   = 1'b1;
            m_addr = aa;
            m_data = ad;
            if (n0 != 0 && starve < MS)
                starve = starve + 1;
        end
        if (popped || n0 == 0)
            starve = 0;
        if (lv && m_ready && la != 0)
            q.push_back('{a: la, d: ld});
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++)
            idle();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (bus.lsu_ready !== 1'b0 || bus.alu_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs ready=%b stall=%b want 0/0",
                     bus.lsu_ready, bus.alu_stall);
        end
        n_cmp++;
        if (bus.reg_write_enable !== 1'b0 || bus.fifo_count !== '0) begin
            n_bad++;
            $display("FAIL reset_out we=%b cnt=%0d want 0/0",
                     bus.reg_write_enable, bus.fifo_count);
        end
        @(negedge clock);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.lsu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release ready=%b want 1", bus.lsu_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++)
            step(1'b1, AW'(2 + i), DW'(32'hA0 + i),
                 1'b1, AW'(20 + i), DW'(32'hB0 + i));
        n_cmp++;
        if (bus.fifo_count !== CW'(3)) begin
            n_bad++;
            $display("FAIL mid_fill cnt=%0d want 3", bus.fifo_count);
        end
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        #3;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.reg_write_enable !== 1'b0 || bus.reg_write_address !== '0 ||
            bus.write_data !== '0) begin
            n_bad++;
            $display("FAIL mid_rst_out we=%b a=%0d d=%h want 0/0/0",
                     bus.reg_write_enable, bus.reg_write_address,
                     bus.write_data);
        end
        n_cmp++;
        if (bus.fifo_count !== '0 || bus.lsu_ready !== 1'b0 ||
            bus.alu_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_hs cnt=%0d rdy=%b st=%b want 0/0/0",
                     bus.fifo_count, bus.lsu_ready, bus.alu_stall);
        end
        @(posedge clock);
        @(negedge clock);
        Reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.lsu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_release ready=%b want 1", bus.lsu_ready);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            n_cmp++;
            if (bus.reg_write_enable !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_stale cyc %0d we=%b want 0",
                         i, bus.reg_write_enable);
            end
        end
    endtask

    task automatic test_alu_only();
        drain();
        step(1'b1, AW'(5), 32'hDEADBEEF, 1'b0, '0, '0);
        n_cmp++;
        if (bus.reg_write_enable !== 1'b1 ||
            bus.reg_write_address !== AW'(5) ||
            bus.write_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL alu_only we=%b a=%0d d=%h want 1/5/deadbeef",
                     bus.reg_write_enable, bus.reg_write_address,
                     bus.write_data);
        end
        idle();
        n_cmp++;
        if (bus.reg_write_enable !== 1'b0 ||
            bus.reg_write_address !== AW'(5) ||
            bus.write_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL alu_hold we=%b a=%0d d=%h want 0/5/deadbeef",
                     bus.reg_write_enable, bus.reg_write_address,
                     bus.write_data);
        end
    endtask

    task automatic test_fifo_fill();
        int   acc;
        logic rdy;
        acc = 0;
        bus2.alu_valid = 1'b1;
        bus2.alu_addr  = AW'(9);
        bus2.alu_data  = 32'h99;
        for (int c = 0; c < 8; c++) begin
            bus2.lsu_valid = 1'b1;
            bus2.lsu_addr  = AW'(10 + acc);
            bus2.lsu_data  = DW'(100 + acc);
            #1;
            rdy = bus2.lsu_ready;
            @(posedge clock);
            #1;
            if (rdy)
                acc++;
        end
        n_cmp++;
        if (acc != 4 || bus2.fifo_count !== CW'(4) ||
            bus2.lsu_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fill acc=%0d cnt=%0d rdy=%b want 4/4/0",
                     acc, bus2.fifo_count, bus2.lsu_ready);
        end
        bus2.alu_valid = 1'b0;
        bus2.lsu_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if (bus2.reg_write_enable !== 1'b1 ||
                bus2.reg_write_address !== AW'(10 + k) ||
                bus2.write_data !== DW'(100 + k)) begin
                n_bad++;
                $display("FAIL drain %0d we=%b a=%0d d=%0d want 1/%0d/%0d",
                         k, bus2.reg_write_enable, bus2.reg_write_address,
                         bus2.write_data, 10 + k, 100 + k);
            end
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (bus2.reg_write_enable !== 1'b0 || bus2.fifo_count !== '0) begin
            n_bad++;
            $display("FAIL drain_end we=%b cnt=%0d want 0/0",
                     bus2.reg_write_enable, bus2.fifo_count);
        end
    endtask

    task automatic test_starvation();
        logic [AW-1:0] rec [5];
        logic [AW-1:0] exp_a [5];
        logic          st4;
        logic [DW-1:0] d4;
        int            got;
        int            r;
        exp_a = '{AW'(1), AW'(2), AW'(3), AW'(7), AW'(4)};
        st4 = 1'b0;
        d4  = '0;
        drain();
        step(1'b1, AW'(9), 32'h99, 1'b1, AW'(7), 32'h11);
        got = 0;
        r   = 1;
        for (int k = 0; k < 10 && got < 5; k++) begin
            step(1'b1, AW'(r), DW'(32'h100 + r), 1'b0, '0, '0);
            if (bus.reg_write_enable === 1'b1) begin
                rec[got] = bus.reg_write_address;
                if (got == 3) begin
                    st4 = s_stall;
                    d4  = bus.write_data;
                end
                got++;
            end
            if (!s_stall)
                r++;
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= got || rec[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL starve_order %0d got %0d want %0d",
                         i, rec[i], exp_a[i]);
            end
        end
        n_cmp++;
        if (st4 !== 1'b1 || d4 !== 32'h11) begin
            n_bad++;
            $display("FAIL starve_force stall=%b d=%h want 1/11", st4, d4);
        end
        n_cmp++;
        if (bus.alu_stall !== 1'b0 || bus.fifo_count !== '0) begin
            n_bad++;
            $display("FAIL starve_after stall=%b cnt=%0d want 0/0",
                     bus.alu_stall, bus.fifo_count);
        end
    endtask

    task automatic test_r0();
        drain();
        idle();
        step(1'b1, '0, 32'h1234, 1'b1, '0, 32'h5678);
        n_cmp++;
        if (s_stall !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL r0_hs stall=%b ready=%b want 0/1",
                     s_stall, s_ready);
        end
        n_cmp++;
        if (bus.reg_write_enable !== 1'b0 || bus.fifo_count !== '0) begin
            n_bad++;
            $display("FAIL r0_write we=%b cnt=%0d want 0/0",
                     bus.reg_write_enable, bus.fifo_count);
        end
    endtask

    task automatic test_full_pop();
        drain();
        for (int i = 0; i < 4; i++)
            step(1'b1, AW'(2), DW'(i), 1'b1, AW'(20 + i), DW'(32'hC0 + i));
        n_cmp++;
        if (bus.fifo_count !== CW'(4)) begin
            n_bad++;
            $display("FAIL full cnt=%0d want 4", bus.fifo_count);
        end
        step(1'b0, '0, '0, 1'b1, AW'(30), 32'hE0);
        n_cmp++;
        if (s_ready !== 1'b0 || bus.fifo_count !== CW'(3) ||
            bus.reg_write_address !== AW'(20)) begin
            n_bad++;
            $display("FAIL full_pop rdy=%b cnt=%0d a=%0d want 0/3/20",
                     s_ready, bus.fifo_count, bus.reg_write_address);
        end
        step(1'b0, '0, '0, 1'b1, AW'(30), 32'hE0);
        n_cmp++;
        if (s_ready !== 1'b1 || bus.fifo_count !== CW'(3)) begin
            n_bad++;
            $display("FAIL full_accept rdy=%b cnt=%0d want 1/3",
                     s_ready, bus.fifo_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 DW'($urandom), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)), DW'($urandom));
            n_cmp++;
            if (s_stall !== m_stall || s_ready !== m_ready ||
                s_cnt !== CW'(m_cnt)) begin
                n_bad++;
                $display("FAIL rnd_hs cyc %0d st=%b rdy=%b cnt=%0d want %b/%b/%0d",
                         c, s_stall, s_ready, s_cnt, m_stall, m_ready, m_cnt);
            end
            n_cmp++;
            if (bus.reg_write_enable !== m_we ||
                bus.reg_write_address !== m_addr ||
                bus.write_data !== m_data) begin
                n_bad++;
                $display("FAIL rnd_wr cyc %0d we=%b a=%0d d=%h want %b/%0d/%h",
                         c, bus.reg_write_enable, bus.reg_write_address,
                         bus.write_data, m_we, m_addr, m_data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b1;
        bus.alu_valid  = 1'b0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_addr   = '0;
        bus.lsu_data   = '0;
        bus2.alu_valid = 1'b0;
        bus2.alu_addr  = '0;
        bus2.alu_data  = '0;
        bus2.lsu_valid = 1'b0;
        bus2.lsu_addr  = '0;
        bus2.lsu_data  = '0;
        model_reset();
        test_reset();
        test_reset_mid_burst();
        test_alu_only();
        test_fifo_fill();
        test_starvation();
        test_r0();
        test_full_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side producer for the CPU register file: merges two writeback sources onto the file's single write port (reg_write_enable / reg_write_address / write_data).
- Source A is the single-cycle ALU path, highest priority, stallable only by this block.
- Source B is the long-latency load/multiply path, buffered in a FIFO with a valid/ready handshake.
- Adds r0 write suppression, starvation protection for source B, and a registered write port.

Parameters:
DATA_W, 32, data width of register writes
ADDR_W, 5, register address width
FIFO_DEPTH, 4, entries in source-B buffer (power of 2, >=2)
MAX_STARVE, 3, consecutive ALU wins while FIFO non-empty before FIFO is forced through (>=1)

Ports:
clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result valid this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_stall  out  1  ALU must hold its result; the ALU write is not taken this cycle
lsu_valid  in  1  source-B write request
lsu_ready  out  1  FIFO can accept; transfer occurs when lsu_valid && lsu_ready
lsu_addr  in  ADDR_W  source-B destination register
lsu_data  in  DATA_W  source-B data
reg_write_enable  out  1  to register file write enable
reg_write_address  out  ADDR_W  to register file write address
write_data  out  DATA_W  to register file write data
fifo_count  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-burst):
  - reg_write_enable=0, reg_write_address=0, write_data=0.
  - FIFO emptied, fifo_count=0, starve_cnt=0.
  - lsu_ready=0 and alu_stall=0 while Reset is high.
  - The first accept is possible on the first clock edge after Reset deasserts.
- lsu_ready = (fifo_count != FIFO_DEPTH). It is computed from registered count only, so a full FIFO does not accept even in a cycle where it pops.
- Source-B handshake with lsu_addr==0: the handshake completes but nothing is enqueued and the count is unchanged.
- Effective ALU request: alu_req = alu_valid && alu_addr!=0. An ALU write to r0 is consumed silently and never stalled.
- alu_stall = (starve_cnt==MAX_STARVE) && (fifo_count!=0). It depends only on registered state, with no combinational path from alu_valid.
- Per-cycle selection, in priority order:
  1. alu_stall=1: pop the FIFO head and issue it. The ALU holds.
  2. Else alu_req: issue the ALU write. If the FIFO is non-empty, starve_cnt increments (saturating at MAX_STARVE).
  3. Else the FIFO is non-empty: pop the head and issue it.
  4. Else: no write.
- starve_cnt clears to 0 on any FIFO pop, and whenever the FIFO is empty at the clock edge.
- Latency: a selected write appears on reg_write_* on the clock edge after selection (1 cycle). reg_write_enable is high exactly one cycle per issued write.
- When no write is issued, reg_write_enable=0 and address/data hold their previous values.
- FIFO behaviour:
  - Strict in-order; push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count never exceeds FIFO_DEPTH and never underflows.
- Same-address conflicts: no merging or reordering. Writes reach the file in issue order, so the later issue wins.
- Max source-B wait at the FIFO head is MAX_STARVE+1 cycles of sustained ALU traffic.

Test Plan:
1. Reset mid-burst:
   - Stimulus: FIFO holds 3 entries, assert Reset asynchronously between edges.
   - Required: outputs go to 0 immediately, fifo_count=0, lsu_ready=0. After release, lsu_ready=1 and no stale writes are issued.
2. ALU only:
   - Stimulus: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF for one cycle.
   - Required: next cycle reg_write_enable=1, reg_write_address=5, write_data=0xDEADBEEF; the cycle after, reg_write_enable=0.
3. FIFO fill:
   - Stimulus: ALU valid every cycle (MAX_STARVE large, e.g. 15), source B offers 5 writes back-to-back.
   - Required: 4 accepted, fifo_count=4, lsu_ready=0 and the 5th held. After ALU stops, the 4 entries drain one per cycle in order.
4. Starvation (MAX_STARVE=3):
   - Stimulus: one FIFO entry (r7=0x11); ALU writes r1..r4 continuously.
   - Required: ALU wins r1,r2,r3. In the 4th cycle alu_stall=1, r7=0x11 is issued, then r4 follows and starve_cnt=0.
5. r0 suppression:
   - Stimulus: ALU write to r0 with value 0x1234 and a source-B write to r0.
   - Required: reg_write_enable stays 0, alu_stall=0, lsu handshake completes, fifo_count unchanged.
6. Full with simultaneous pop:
   - Stimulus: FIFO full, ALU idle, lsu_valid=1.
   - Required: head pops, lsu_ready=0 that cycle, count 4→3. Accept occurs the following cycle.
